// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer: stage indices, FSM states, control patterns.
package pipe_ctrl_pkg;

    localparam int unsigned NUM_STG        = 5;
    localparam int unsigned REG_W          = 5;
    localparam int unsigned PERF_W         = 32;
    localparam int unsigned MDU_CYCLES_DEF = 8;
    localparam int unsigned CNT_W_DEF      = 8;

    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [NUM_STG-1:0] stall;
        logic [NUM_STG-1:0] flush;
    } stage_ctrl_t;

    function automatic logic [NUM_STG-1:0] stg_bit(input int unsigned idx);
        return NUM_STG'(1) << idx;
    endfunction

    localparam stage_ctrl_t CTRL_IDLE     = '{stall: '0, flush: '0};
    localparam stage_ctrl_t CTRL_REDIRECT = '{stall: '0,
                                              flush: stg_bit(STG_IFID) | stg_bit(STG_IDEX)};
    localparam stage_ctrl_t CTRL_MDU_HOLD = '{stall: stg_bit(STG_PC) | stg_bit(STG_IFID) | stg_bit(STG_IDEX),
                                              flush: stg_bit(STG_EXMEM)};
    localparam stage_ctrl_t CTRL_LOAD_USE = '{stall: stg_bit(STG_PC) | stg_bit(STG_IFID),
                                              flush: stg_bit(STG_IDEX)};

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Combinational load-use comparator; also reusable by the forwarding unit.
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_mem_rd_i,
    input  logic [REG_W-1:0] ex_waddr_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_rs_rd_i,
    input  logic             id_rt_rd_i,
    output logic             hazard_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_rs_rd_i && (id_rs_i == ex_waddr_i);
    assign rt_hit   = id_rt_rd_i && (id_rt_i == ex_waddr_i);
    assign hazard_o = ex_mem_rd_i && (ex_waddr_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: Mealy stall/flush generation for redirects, load-use and multi-cycle MDU ops.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_mem_rd,
    input  logic [REG_W-1:0]   ex_waddr,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_rs_rd,
    input  logic               id_rt_rd,
    input  logic               ex_to_pc,
    input  logic               ex_mdu_start,
    output logic [NUM_STG-1:0] stall,
    output logic [NUM_STG-1:0] flush,
    output logic               mdu_busy,
    output logic               mdu_done,
    output logic [PERF_W-1:0]  perf_stall_cnt,
    output logic [PERF_W-1:0]  perf_flush_cnt
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    stage_ctrl_t       ctrl;
    logic              busy_c;
    logic              done_c;
    logic              load_use;

    pipe_hazard_cmp u_hazard_cmp (
        .ex_mem_rd_i (ex_mem_rd),
        .ex_waddr_i  (ex_waddr),
        .id_rs_i     (id_rs),
        .id_rt_i     (id_rt),
        .id_rs_rd_i  (id_rs_rd),
        .id_rt_rd_i  (id_rt_rd),
        .hazard_o    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_IDLE;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            RUN: begin
                // Redirect squashes the wrong-path ID instruction, so its hazard is moot.
                if (ex_to_pc) begin
                    ctrl = CTRL_REDIRECT;
                end else if (ex_mdu_start) begin
                    ctrl    = CTRL_MDU_HOLD;
                    busy_c  = 1'b1;
                    cnt_d   = CNT_W'(MDU_CYCLES - 2);
                    state_d = MDU_WAIT;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            MDU_WAIT: begin
                busy_c = 1'b1;
                if (cnt_q != '0) begin
                    ctrl  = CTRL_MDU_HOLD;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_c  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs forced quiet while reset is held, regardless of input activity.
    assign stall    = rst_n ? ctrl.stall : '0;
    assign flush    = rst_n ? ctrl.flush : '0;
    assign mdu_busy = rst_n && busy_c;
    assign mdu_done = rst_n && done_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;
    logic              redirect_c;

    assign redirect_c = (state_q == RUN) && ex_to_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall[STG_PC] && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
            if (redirect_c && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

`ifndef SYNTHESIS
    a_no_redirect_with_mdu: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_to_pc && ex_mdu_start))
        else $error("pipe_ctrl: ex_to_pc and ex_mdu_start asserted together");
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations, negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int unsigned MDU = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_mem_rd = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_rs_rd = 1'b0;
    logic        id_rt_rd = 1'b0;
    logic        ex_to_pc = 1'b0;
    logic        ex_mdu_start = 1'b0;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    pipe_ctrl #(.MDU_CYCLES(MDU), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_mem_rd      (ex_mem_rd),
        .ex_waddr       (ex_waddr),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_rd       (id_rs_rd),
        .id_rt_rd       (id_rt_rd),
        .ex_to_pc       (ex_to_pc),
        .ex_mdu_start   (ex_mdu_start),
        .stall          (stall),
        .flush          (flush),
        .mdu_busy       (mdu_busy),
        .mdu_done       (mdu_done),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        busy;
        logic        done;
        logic [31:0] pstall;
        logic [31:0] pflush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    // Reference model state: whether an MDU op is active and the cycle it began.
    int          cyc = 0;
    bit          m_in_mdu = 0;
    int          m_start_cyc = 0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_flush_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, c, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input logic [4:0] wa, input logic [4:0] rs,
                         input logic [4:0] rt, input bit rsr, input bit rtr, input bit pc, input bit st);
        exp_t e;
        bit   haz;
        int   k;
        @(posedge clk);
        #1;
        rst_n = r; ex_mem_rd = ld; ex_waddr = wa; id_rs = rs; id_rt = rt;
        id_rs_rd = rsr; id_rt_rd = rtr; ex_to_pc = pc; ex_mdu_start = st;
        e = '{cyc: cyc, stall: 5'b0, flush: 5'b0, busy: 1'b0, done: 1'b0, pstall: 32'd0, pflush: 32'd0};
        haz = ld && (wa != 5'd0) && ((rsr && rs == wa) || (rtr && rt == wa));
        if (!r) begin
            m_in_mdu = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
`ifdef PIPE_CTRL_PERF_EN
            e.pstall = m_stall_cnt;
            e.pflush = m_flush_cnt;
`endif
            if (m_in_mdu) begin
                k = cyc - m_start_cyc;
                e.busy = 1'b1;
                if (k < int'(MDU) - 1) begin
                    e.stall = 5'b00111; e.flush = 5'b01000;
                end else begin
                    e.done = 1'b1;
                    m_in_mdu = 0;
                end
            end else if (pc) begin
                e.flush = 5'b00110;
                m_flush_cnt++;
            end else if (st) begin
                e.stall = 5'b00111; e.flush = 5'b01000; e.busy = 1'b1;
                m_in_mdu = 1;
                m_start_cyc = cyc;
            end else if (haz) begin
                e.stall = 5'b00011; e.flush = 5'b00100;
            end
            if (e.stall[0]) m_stall_cnt++;
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: Mealy outputs are settled by the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",      32'(stall),    32'(e.stall), e.cyc);
                check("flush",      32'(flush),    32'(e.flush), e.cyc);
                check("mdu_busy",   32'(mdu_busy), 32'(e.busy),  e.cyc);
                check("mdu_done",   32'(mdu_done), 32'(e.done),  e.cyc);
                check("perf_stall", perf_stall_cnt, e.pstall,    e.cyc);
                check("perf_flush", perf_flush_cnt, e.pflush,    e.cyc);
            end
        end
    end

    initial begin
        bit pc;
        bit st;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 3, 0, 1, 0, 0, 0);
        idle(2);
        // Load-use variants
        drive(1, 1, 3, 3, 0, 1, 0, 0, 0);
        idle(1);
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0);
        drive(1, 1, 5, 1, 5, 0, 1, 0, 0);
        drive(1, 1, 7, 7, 2, 0, 1, 0, 0);
        drive(1, 0, 3, 3, 3, 1, 1, 0, 0);
        // Redirect beats hazard
        drive(1, 1, 3, 3, 0, 1, 0, 1, 0);
        idle(1);
        // MDU op with interference during the wait
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 3, 3, 0, 1, 0, 1, 0);
        drive(1, 1, 4, 0, 4, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 3, 3, 0, 1, 0, 1, 0);
        idle(2);
        drive(1, 1, 2, 2, 0, 1, 0, 0, 0);
        drive(1, 1, 2, 2, 0, 1, 0, 0, 0);
        idle(1);
        // Reset in the middle of an MDU op, then a fresh op
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(MDU);
        // Back-to-back MDU ops from a clean reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(MDU - 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(MDU - 1);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            pc = ($urandom_range(7) == 0);
            st = !pc && ($urandom_range(9) == 0);
            drive(($urandom_range(79) != 0), 1'($urandom_range(1)), 5'($urandom_range(3)),
                  5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), pc, st);
        end
        idle(1);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0, cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
